// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

  typedef logic [31:0] InsnPath;
  typedef logic [31:0] InsnAddrPath;

  localparam int IMEM_STARVE_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } ImemOwner;

endpackage

// File: rtl/imem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles debug lost arbitration to fetch.
module imem_starve_counter
  import imem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_valid,
  input  logic dbg_grant,
  input  logic fetch_grant,
  output logic starve_hit
);

  localparam logic [IMEM_STARVE_CNT_WIDTH-1:0] LIMIT = IMEM_STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic [IMEM_STARVE_CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (dbg_grant || !dbg_valid) begin
      cnt <= '0;
    end else if (fetch_grant && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve_hit = (cnt == LIMIT);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single synchronous-read IMem port between fetch (priority) and debug,
// routing each one-cycle-late read back to the requester that issued it.
//   owner     | meaning
//   OWN_NONE  | no read issued last cycle, mem_insn is not claimed
//   OWN_FETCH | mem_insn is fetch's read (dropped if flush is high)
//   OWN_DBG   | mem_insn is debug's read
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_valid,
  input  InsnAddrPath fetch_req_addr,
  output logic        fetch_req_ready,
  output logic        fetch_rsp_valid,
  output InsnPath     fetch_rsp_insn,
  input  logic        dbg_req_valid,
  input  InsnAddrPath dbg_req_addr,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output InsnPath     dbg_rsp_insn,
  input  logic        flush,
  output InsnAddrPath mem_addr,
  input  InsnPath     mem_insn
);

  ImemOwner    owner;
  InsnAddrPath last_addr;
  logic        fetch_eligible;
  logic        fetch_grant;
  logic        dbg_grant;
  logic        starve_hit;

  assign fetch_eligible = fetch_req_valid && !flush;
  assign fetch_grant    = fetch_eligible && !(dbg_req_valid && starve_hit);
  assign dbg_grant      = dbg_req_valid && !fetch_grant;

  assign fetch_req_ready = fetch_grant;
  assign dbg_req_ready   = dbg_grant;

  always_comb begin
    mem_addr = last_addr;
    if (fetch_grant) begin
      mem_addr = fetch_req_addr;
    end else if (dbg_grant) begin
      mem_addr = dbg_req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      last_addr <= '0;
    end else begin
      if (fetch_grant) begin
        owner <= OWN_FETCH;
      end else if (dbg_grant) begin
        owner <= OWN_DBG;
      end else begin
        owner <= OWN_NONE;
      end
      if (fetch_grant || dbg_grant) begin
        last_addr <= mem_addr;
      end
    end
  end

  // A redirect makes the fetch data arriving this cycle stale.
  assign fetch_rsp_valid = (owner == OWN_FETCH) && !flush;
  assign dbg_rsp_valid   = (owner == OWN_DBG);
  assign fetch_rsp_insn  = mem_insn;
  assign dbg_rsp_insn    = mem_insn;

  imem_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .dbg_valid  (dbg_req_valid),
    .dbg_grant  (dbg_grant),
    .fetch_grant(fetch_grant),
    .starve_hit (starve_hit)
  );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous-read IMem.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_addr;
  logic        fetch_req_ready;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_insn;
  logic        dbg_req_valid;
  logic [31:0] dbg_req_addr;
  logic        dbg_req_ready;
  logic        dbg_rsp_valid;
  logic [31:0] dbg_rsp_insn;
  logic        flush;
  logic [31:0] mem_addr;
  logic [31:0] mem_insn;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_bad = 0;

  imem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_addr (fetch_req_addr),
    .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_insn (fetch_rsp_insn),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_addr   (dbg_req_addr),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_rsp_valid  (dbg_rsp_valid),
    .dbg_rsp_insn   (dbg_rsp_insn),
    .flush          (flush),
    .mem_addr       (mem_addr),
    .mem_insn       (mem_insn)
  );

  always #5 clk = ~clk;

  // mem[i] = 0xC0DE0000 + i, word address = byte address >> 2
  initial for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

  always @(posedge clk) mem_insn <= mem[mem_addr[7:2]];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic dv,
                       input logic [31:0] da, input logic fl);
    fetch_req_valid = fv;
    fetch_req_addr  = fa;
    dbg_req_valid   = dv;
    dbg_req_addr    = da;
    flush           = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_rsp_valid got %b want 0", fetch_rsp_valid); end
    n_cmp++; if (dbg_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dbg_rsp_valid got %b want 0", dbg_rsp_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (dut.u_starve.cnt !== 4'd0) begin n_bad++; $display("FAIL reset_starve_cnt got %0d want 0", dut.u_starve.cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    logic [31:0] exp_insn [0:2];
    exp_insn[0] = 32'hC0DE_0000;
    exp_insn[1] = 32'hC0DE_0001;
    exp_insn[2] = 32'hC0DE_0002;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 32'(c * 4), 1'b0, 32'h0, 1'b0);
      else       drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      if (c < 3) begin
        n_cmp++; if (fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_only_ready c%0d got %b want 1", c, fetch_req_ready); end
        n_cmp++; if (mem_addr !== 32'(c * 4)) begin n_bad++; $display("FAIL fetch_only_mem_addr c%0d got %h want %h", c, mem_addr, c * 4); end
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (fetch_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL fetch_only_rsp_valid c%0d got %b want 1", c, fetch_rsp_valid); end
        n_cmp++; if (fetch_rsp_insn !== exp_insn[c-1]) begin n_bad++; $display("FAIL fetch_only_rsp_insn c%0d got %h want %h", c, fetch_rsp_insn, exp_insn[c-1]); end
      end else begin
        n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_only_rsp_idle c%0d got %b want 0", c, fetch_rsp_valid); end
      end
      n_cmp++; if (dbg_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_only_dbg_rsp c%0d got %b want 0", c, dbg_rsp_valid); end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_dbg;
    exp_dbg = 10'b10_0001_0000;
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
      else        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      if (c < 10) begin
        n_cmp++; if (fetch_req_ready !== !exp_dbg[c]) begin n_bad++; $display("FAIL starve_fetch_ready c%0d got %b want %b", c, fetch_req_ready, !exp_dbg[c]); end
        n_cmp++; if (dbg_req_ready !== exp_dbg[c]) begin n_bad++; $display("FAIL starve_dbg_ready c%0d got %b want %b", c, dbg_req_ready, exp_dbg[c]); end
        n_cmp++; if (mem_addr !== (exp_dbg[c] ? 32'h80 : 32'h40)) begin n_bad++; $display("FAIL starve_mem_addr c%0d got %h", c, mem_addr); end
      end
      if (c >= 1) begin
        n_cmp++; if (dbg_rsp_valid !== exp_dbg[c-1]) begin n_bad++; $display("FAIL starve_dbg_rsp_valid c%0d got %b want %b", c, dbg_rsp_valid, exp_dbg[c-1]); end
        n_cmp++; if (fetch_rsp_valid !== !exp_dbg[c-1]) begin n_bad++; $display("FAIL starve_fetch_rsp_valid c%0d got %b want %b", c, fetch_rsp_valid, !exp_dbg[c-1]); end
        if (exp_dbg[c-1]) begin
          n_cmp++; if (dbg_rsp_insn !== 32'hC0DE_0020) begin n_bad++; $display("FAIL starve_dbg_rsp_insn c%0d got %h want c0de0020", c, dbg_rsp_insn); end
        end else begin
          n_cmp++; if (fetch_rsp_insn !== 32'hC0DE_0010) begin n_bad++; $display("FAIL starve_fetch_rsp_insn c%0d got %h want c0de0010", c, fetch_rsp_insn); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush_fetch();
    drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_f_grant got %b want 1", fetch_req_ready); end
    next_cycle();
    drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_f_rsp_suppressed got %b want 0", fetch_rsp_valid); end
    n_cmp++; if (fetch_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_f_ready_blocked got %b want 0", fetch_req_ready); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL flush_f_mem_addr_hold got %h want 10", mem_addr); end
    next_cycle();
    drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_f_regrant got %b want 1", fetch_req_ready); end
    n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_f_no_rsp_after got %b want 0", fetch_rsp_valid); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (fetch_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL flush_f_rsp_valid got %b want 1", fetch_rsp_valid); end
    n_cmp++; if (fetch_rsp_insn !== 32'hC0DE_0005) begin n_bad++; $display("FAIL flush_f_rsp_insn got %h want c0de0005", fetch_rsp_insn); end
    next_cycle();
  endtask

  task automatic test_flush_dbg();
    drive(1'b0, 32'h0, 1'b1, 32'h24, 1'b0);
    @(negedge clk);
    n_cmp++; if (dbg_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_d_grant got %b want 1", dbg_req_ready); end
    next_cycle();
    drive(1'b1, 32'h14, 1'b1, 32'h28, 1'b1);
    @(negedge clk);
    n_cmp++; if (dbg_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL flush_d_rsp_valid got %b want 1", dbg_rsp_valid); end
    n_cmp++; if (dbg_rsp_insn !== 32'hC0DE_0009) begin n_bad++; $display("FAIL flush_d_rsp_insn got %h want c0de0009", dbg_rsp_insn); end
    n_cmp++; if (fetch_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_d_fetch_ready got %b want 0", fetch_req_ready); end
    n_cmp++; if (dbg_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_d_dbg_ready got %b want 1", dbg_req_ready); end
    n_cmp++; if (mem_addr !== 32'h28) begin n_bad++; $display("FAIL flush_d_mem_addr got %h want 28", mem_addr); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (dbg_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL flush_d_rsp2_valid got %b want 1", dbg_rsp_valid); end
    n_cmp++; if (dbg_rsp_insn !== 32'hC0DE_000A) begin n_bad++; $display("FAIL flush_d_rsp2_insn got %h want c0de000a", dbg_rsp_insn); end
    n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_d_fetch_rsp got %b want 0", fetch_rsp_valid); end
    next_cycle();
  endtask

  task automatic test_idle_hold();
    drive(1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    @(negedge clk);
    n_cmp++; if (dbg_req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_dbg_grant got %b want 1", dbg_req_ready); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_addr !== 32'h20) begin n_bad++; $display("FAIL idle_mem_addr c%0d got %h want 20", c, mem_addr); end
      n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_fetch_rsp c%0d got %b want 0", c, fetch_rsp_valid); end
      n_cmp++; if (dbg_rsp_valid !== (c == 1)) begin n_bad++; $display("FAIL idle_dbg_rsp c%0d got %b want %b", c, dbg_rsp_valid, c == 1); end
      if (c == 1) begin
        n_cmp++; if (dbg_rsp_insn !== 32'hC0DE_0008) begin n_bad++; $display("FAIL idle_dbg_rsp_insn got %h want c0de0008", dbg_rsp_insn); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h30, 1'b1, 32'h80, 1'b0);
    next_cycle();
    @(negedge clk);
    n_cmp++; if (fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant got %b want 1", fetch_req_ready); end
    n_cmp++; if (dut.u_starve.cnt !== 4'd1) begin n_bad++; $display("FAIL rstmid_cnt_before got %0d want 1", dut.u_starve.cnt); end
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (fetch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_fetch_rsp c%0d got %b want 0", c, fetch_rsp_valid); end
      n_cmp++; if (dbg_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_dbg_rsp c%0d got %b want 0", c, dbg_rsp_valid); end
      n_cmp++; if (dut.u_starve.cnt !== 4'd0) begin n_bad++; $display("FAIL rstmid_cnt c%0d got %0d want 0", c, dut.u_starve.cnt); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rstmid_mem_addr c%0d got %h want 0", c, mem_addr); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_starvation();
    test_flush_fetch();
    test_flush_dbg();
    test_idle_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
